analog_sensor_reader: RTL and testbench
=======================================

Name: analog_sensor_reader

Overview:
- CPU-side consumer of the analog sensor's ready/complete handshake; the reader at the far end of the AnalogSensor interface.
- Drives Mode/Enable into the sensor and captures each 16-bit AnalogReading when AnalogValReady is high.
- Acknowledges each sample with CPUReadComplete using a four-phase handshake, and buffers samples in a small FIFO for software.
- Sits between the sensor block and the peripheral register bank of the sensor-fusion SoC peripheral.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- ACK_TIMEOUT, 64, cycles allowed for AnalogValReady to fall after CPUReadComplete rises.

Ports:
- Clk  in  1  single clock, rising edge.
- Rst_n  in  1  reset; asynchronous, active-low.
- CfgMode  in  2  requested mode from register bank (0 Stop, 1 Fast, 2 Slow, 3 reserved).
- CfgEnable  in  1  requested enable.
- Mode  out  2  registered mode to sensor.
- Enable  out  1  registered enable to sensor.
- AnalogReading  in  16  sensor sample, valid while AnalogValReady=1.
- ErrorCode  in  3  sensor status, captured with each sample.
- AnalogValReady  in  1  sensor data-ready.
- CPUReadComplete  out  1  acknowledge to sensor.
- PopReq  in  1  one-cycle pop strobe from software side.
- PopData  out  16  head-of-FIFO sample.
- PopCode  out  3  ErrorCode stored with head sample.
- FifoCount  out  $clog2(DEPTH)+1  occupancy.
- FifoEmpty  out  1  FifoCount==0.
- Stalled  out  1  sample pending but FIFO full.
- TimeoutErr  out  1  sticky handshake-timeout flag.
- ClrErr  in  1  clears TimeoutErr.

Behaviour:
- Reset (async assert, sync release): Mode=0, Enable=0, CPUReadComplete=0, FIFO empty, FifoCount=0, FifoEmpty=1, PopData=0, PopCode=0, Stalled=0, TimeoutErr=0, FSM=IDLE.
- Mode/Enable: CfgMode/CfgEnable registered one cycle. CfgMode=3 is not forwarded; Mode holds its previous value.
- FSM states: IDLE, WAIT_READY, ACK, WAIT_DROP.
  - IDLE: go to WAIT_READY when Enable=1.
  - WAIT_READY: if Enable=0, go to IDLE. If AnalogValReady=1 and the FIFO is not full, push {ErrorCode, AnalogReading} this edge, set CPUReadComplete=1, go to ACK. If AnalogValReady=1 and the FIFO is full, stay and set Stalled=1. The sample is never dropped; the sensor is held in its ready state.
  - ACK: CPUReadComplete stays 1. When AnalogValReady=0, clear CPUReadComplete and go to WAIT_DROP. The timeout counter increments each cycle in ACK. When it reaches ACK_TIMEOUT, set TimeoutErr=1, clear CPUReadComplete and go to WAIT_DROP.
  - WAIT_DROP: one-cycle guard with CPUReadComplete=0. Go to WAIT_READY if Enable=1, else IDLE. This guarantees at least one low cycle between acks.
- Latency: AnalogValReady sampled high at edge N gives CPUReadComplete=1 and FifoCount+1 visible after edge N.
- Disable mid-handshake: ACK/WAIT_DROP complete normally; Enable=0 takes effect only in WAIT_READY or WAIT_DROP.
- Mode change mid-handshake has no effect on the FSM.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - PopData/PopCode are combinationally the head entry; they hold the last popped value when empty.
  - PopReq when empty is ignored.
  - Simultaneous push and pop: count unchanged, both take effect. This applies even when full, so a pop frees space for the same-cycle push.
- Stalled clears on the cycle the pending push succeeds.
- TimeoutErr is sticky. ClrErr clears it; a timeout event in the same cycle as ClrErr wins (set).

Decomposition:
- Shared package analog_sensor_pkg holds:
  - mode enum (STOP=2'd0, FAST=2'd1, SLOW=2'd2);
  - ErrorCode constants (0 Stop, 1 Idle, 2 Fast, 3 Slow);
  - reader FSM state typedef;
  - sample struct {code[2:0], data[15:0]}.
- One sub-module: sample_fifo (parameterised DEPTH, width 19; push/pop/count/empty/full).

Test Plan:
- Enable=1, CfgMode=2, sensor model presents 1234 -> Mode=2 one cycle later; CPUReadComplete rises one cycle after AnalogValReady; PopData=1234, FifoCount=1; CPUReadComplete falls the cycle after AnalogValReady drops.
- Five samples (100..104) with no pops, DEPTH=4 -> FifoCount=4, Stalled=1, AnalogValReady held with no ack. One PopReq -> PopData=100, the fifth sample is pushed, Stalled=0. Drain yields 101,102,103,104.
- Sensor holds AnalogValReady high after ack -> after 64 cycles TimeoutErr=1 and CPUReadComplete=0. ClrErr alone clears it; ClrErr in the same cycle as a new timeout leaves it 1.
- Switch CfgMode 2->1 during ACK -> handshake completes, Mode=1 afterwards, with no extra or missing FIFO entry.
- Assert Rst_n=0 mid-ACK with FifoCount=2 -> all outputs return to reset values immediately (async). After release the FSM sits in IDLE until Enable.
- PopReq on empty FIFO -> FifoCount stays 0 and PopData unchanged. Push and pop in the same cycle at count=1 -> count stays 1, head advances.

Source files
------------

// File: rtl/analog_sensor_pkg.sv
// Shared types and constants for the analog sensor reader slice.
package analog_sensor_pkg;

    // Sensor operating mode as driven on Mode.
    typedef enum logic [1:0] {
        STOP = 2'd0,
        FAST = 2'd1,
        SLOW = 2'd2
    } mode_e;

    // Encoding 3 is reserved and never forwarded to the sensor.
    localparam logic [1:0] MODE_RESERVED = 2'd3;

    // Status codes the sensor reports alongside each sample.
    localparam logic [2:0] ERR_STOP = 3'd0;
    localparam logic [2:0] ERR_IDLE = 3'd1;
    localparam logic [2:0] ERR_FAST = 3'd2;
    localparam logic [2:0] ERR_SLOW = 3'd3;

    // Reader handshake FSM.
    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWaitReady = 2'd1,
        StAck       = 2'd2,
        StWaitDrop  = 2'd3
    } reader_state_e;

    // One buffered sample: status code plus reading.
    typedef struct packed {
        logic [2:0]  code;
        logic [15:0] data;
    } sample_t;

    localparam int unsigned SAMPLE_WIDTH = $bits(sample_t);

endpackage

// File: rtl/sample_fifo.sv
// Circular-buffer FIFO; head is presented combinationally and holds the
// last popped entry while empty. A pop frees space for a same-cycle push.
module sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 19,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] last_popped;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? last_popped : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            last_popped <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr      <= rd_ptr + AW'(1);
                last_popped <= mem[rd_ptr];
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage array; no reset needed since reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/analog_sensor_reader.sv
// Reader side of the analog sensor ready/complete four-phase handshake.
// Forwards mode/enable, captures samples into a FIFO and flags stalls and
// acknowledge timeouts.
module analog_sensor_reader
    import analog_sensor_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [1:0]               CfgMode,
    input  logic                     CfgEnable,
    output logic [1:0]               Mode,
    output logic                     Enable,
    input  logic [15:0]              AnalogReading,
    input  logic [2:0]               ErrorCode,
    input  logic                     AnalogValReady,
    output logic                     CPUReadComplete,
    input  logic                     PopReq,
    output logic [15:0]              PopData,
    output logic [2:0]               PopCode,
    output logic [$clog2(DEPTH):0]   FifoCount,
    output logic                     FifoEmpty,
    output logic                     Stalled,
    input  logic                     ClrErr,
    output logic                     TimeoutErr
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    mode_e            mode_reg;
    logic             enable_reg;
    reader_state_e    state, state_next;
    logic             ack, ack_next;
    logic             stalled, stalled_next;
    logic             tmo_err, tmo_err_next;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_next;
    logic             timeout_evt;
    logic             push;
    logic             pop;
    logic             can_push;
    logic             fifo_full;
    logic             fifo_empty;
    sample_t          push_sample;
    sample_t          head_sample;

    assign Mode            = mode_reg;
    assign Enable          = enable_reg;
    assign CPUReadComplete = ack;
    assign Stalled         = stalled;
    assign TimeoutErr      = tmo_err;
    assign FifoEmpty       = fifo_empty;
    assign PopData         = head_sample.data;
    assign PopCode         = head_sample.code;

    assign pop         = PopReq && !fifo_empty;
    assign can_push    = !fifo_full || pop;
    assign push_sample = '{code: ErrorCode, data: AnalogReading};

    // Register configuration; the reserved mode encoding leaves Mode unchanged.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mode_reg   <= STOP;
            enable_reg <= 1'b0;
        end else begin
            enable_reg <= CfgEnable;
            if (CfgMode != MODE_RESERVED) begin
                mode_reg <= mode_e'(CfgMode);
            end
        end
    end

    // Handshake next-state: push on accept, hold the sensor while full.
    always_comb begin
        state_next   = state;
        ack_next     = ack;
        stalled_next = 1'b0;
        tmo_cnt_next = tmo_cnt;
        timeout_evt  = 1'b0;
        push         = 1'b0;
        unique case (state)
            StIdle: begin
                if (enable_reg) begin
                    state_next = StWaitReady;
                end
            end
            StWaitReady: begin
                if (!enable_reg) begin
                    state_next = StIdle;
                end else if (AnalogValReady) begin
                    if (can_push) begin
                        push         = 1'b1;
                        ack_next     = 1'b1;
                        tmo_cnt_next = '0;
                        state_next   = StAck;
                    end else begin
                        stalled_next = 1'b1;
                    end
                end
            end
            StAck: begin
                if (!AnalogValReady) begin
                    ack_next   = 1'b0;
                    state_next = StWaitDrop;
                end else if (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    timeout_evt = 1'b1;
                    ack_next    = 1'b0;
                    state_next  = StWaitDrop;
                end else begin
                    tmo_cnt_next = tmo_cnt + CNT_W'(1);
                end
            end
            StWaitDrop: begin
                state_next = enable_reg ? StWaitReady : StIdle;
            end
            default: state_next = StIdle;
        endcase
        // A timeout in the same cycle as a clear request wins.
        tmo_err_next = timeout_evt ? 1'b1 : (ClrErr ? 1'b0 : tmo_err);
    end

    // Handshake state registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= StIdle;
            ack     <= 1'b0;
            stalled <= 1'b0;
            tmo_err <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_next;
            ack     <= ack_next;
            stalled <= stalled_next;
            tmo_err <= tmo_err_next;
            tmo_cnt <= tmo_cnt_next;
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_WIDTH)
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .push      (push),
        .push_data (push_sample),
        .pop       (pop),
        .head      (head_sample),
        .count     (FifoCount),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_analog_sensor_reader.sv
// Self-checking bench for analog_sensor_reader: directed handshake scenarios
// followed by randomized traffic against a transaction-level sample queue.
module tb_analog_sensor_reader;

    localparam int unsigned DEPTH       = 4;
    localparam int unsigned ACK_TIMEOUT = 64;
    localparam int unsigned CW          = $clog2(DEPTH) + 1;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic [1:0]    CfgMode = 2'd0;
    logic          CfgEnable = 1'b0;
    logic [1:0]    Mode;
    logic          Enable;
    logic [15:0]   AnalogReading = 16'd0;
    logic [2:0]    ErrorCode = 3'd0;
    logic          AnalogValReady = 1'b0;
    logic          CPUReadComplete;
    logic          PopReq = 1'b0;
    logic [15:0]   PopData;
    logic [2:0]    PopCode;
    logic [CW-1:0] FifoCount;
    logic          FifoEmpty;
    logic          Stalled;
    logic          ClrErr = 1'b0;
    logic          TimeoutErr;

    analog_sensor_reader #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .CfgMode         (CfgMode),
        .CfgEnable       (CfgEnable),
        .Mode            (Mode),
        .Enable          (Enable),
        .AnalogReading   (AnalogReading),
        .ErrorCode       (ErrorCode),
        .AnalogValReady  (AnalogValReady),
        .CPUReadComplete (CPUReadComplete),
        .PopReq          (PopReq),
        .PopData         (PopData),
        .PopCode         (PopCode),
        .FifoCount       (FifoCount),
        .FifoEmpty       (FifoEmpty),
        .Stalled         (Stalled),
        .ClrErr          (ClrErr),
        .TimeoutErr      (TimeoutErr)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: samples accepted by the reader, oldest first.
    logic [18:0] q [$];
    logic [1:0]  exp_mode;
    int          ph = 0;
    int          hold = 0;
    int          n_acc = 0;
    logic [15:0] last_pop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ack(input logic val, input string tag);
        int n = 0;
        while (CPUReadComplete !== val && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, CPUReadComplete, val);
    endtask

    task automatic send(input logic [15:0] d, input logic [2:0] c);
        AnalogReading  = d;
        ErrorCode      = c;
        AnalogValReady = 1'b1;
        wait_ack(1'b1, "send_ack_rise");
        AnalogValReady = 1'b0;
        wait_ack(1'b0, "send_ack_fall");
    endtask

    task automatic pop_one(input logic [15:0] exp, input string tag);
        check_eq(tag, PopData, exp);
        PopReq = 1'b1;
        tick();
        PopReq = 1'b0;
        last_pop = exp;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_mode"}, Mode, 0);
        check_eq({tag, "_enable"}, Enable, 0);
        check_eq({tag, "_ack"}, CPUReadComplete, 0);
        check_eq({tag, "_count"}, FifoCount, 0);
        check_eq({tag, "_empty"}, FifoEmpty, 1);
        check_eq({tag, "_popdata"}, PopData, 0);
        check_eq({tag, "_popcode"}, PopCode, 0);
        check_eq({tag, "_stalled"}, Stalled, 0);
        check_eq({tag, "_tmoerr"}, TimeoutErr, 0);
    endtask

    // One randomized cycle: sensor agent, random pops/mode, model update.
    task automatic step_random(input bit allow_new);
        logic       pop_now;
        logic [1:0] cfg_prev;
        PopReq = ($urandom_range(0, 2) == 0);
        if (allow_new && $urandom_range(0, 15) == 0) CfgMode = 2'($urandom_range(0, 3));
        pop_now = PopReq && (q.size() > 0);
        if (pop_now) begin
            check_eq("rnd_pop_data", PopData, q[0][15:0]);
            check_eq("rnd_pop_code", PopCode, q[0][18:16]);
        end
        cfg_prev = CfgMode;
        tick();
        if (pop_now) void'(q.pop_front());
        if (ph == 1) begin
            if (CPUReadComplete) begin
                q.push_back({ErrorCode, AnalogReading});
                n_acc++;
                ph   = 2;
                hold = $urandom_range(0, 3);
            end
        end else if (ph == 2) begin
            if (!AnalogValReady && !CPUReadComplete) ph = 0;
            else if (hold > 0) hold--;
            else AnalogValReady = 1'b0;
        end else if (allow_new && $urandom_range(0, 1) == 1) begin
            AnalogReading  = 16'($urandom);
            ErrorCode      = 3'($urandom_range(0, 7));
            AnalogValReady = 1'b1;
            ph             = 1;
        end
        if (cfg_prev != 2'd3) exp_mode = cfg_prev;
        check_eq("rnd_count", FifoCount, q.size());
        check_eq("rnd_empty", FifoEmpty, q.size() == 0);
        check_eq("rnd_mode", Mode, exp_mode);
        check_eq("rnd_tmoerr", TimeoutErr, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        tick();
        tick();
        check_reset_outputs("reset");
        Rst_n = 1'b1;
        tick();

        // Basic sample, slow mode.
        CfgEnable = 1'b1;
        CfgMode   = 2'd2;
        tick();
        check_eq("t1_mode", Mode, 2);
        check_eq("t1_enable", Enable, 1);
        tick();
        AnalogReading  = 16'd1234;
        ErrorCode      = 3'd3;
        AnalogValReady = 1'b1;
        check_eq("t1_ack_before", CPUReadComplete, 0);
        tick();
        check_eq("t1_ack_rise", CPUReadComplete, 1);
        check_eq("t1_count", FifoCount, 1);
        check_eq("t1_popdata", PopData, 1234);
        check_eq("t1_popcode", PopCode, 3);
        repeat (3) tick();
        check_eq("t1_ack_held", CPUReadComplete, 1);
        AnalogValReady = 1'b0;
        tick();
        check_eq("t1_ack_fall", CPUReadComplete, 0);
        tick();
        pop_one(16'd1234, "t1_pop");
        check_eq("t1_count_after_pop", FifoCount, 0);
        check_eq("t1_empty_after_pop", FifoEmpty, 1);
        check_eq("t1_popdata_held", PopData, 1234);

        // Fill to full, stall, pop releases the pending sample.
        for (int i = 0; i < 4; i++) send(16'(100 + i), 3'(i));
        check_eq("t2_count_full", FifoCount, 4);
        AnalogReading  = 16'd104;
        ErrorCode      = 3'd4;
        AnalogValReady = 1'b1;
        repeat (3) tick();
        check_eq("t2_stalled", Stalled, 1);
        check_eq("t2_no_ack", CPUReadComplete, 0);
        check_eq("t2_count_stalled", FifoCount, 4);
        check_eq("t2_head", PopData, 100);
        PopReq = 1'b1;
        tick();
        PopReq = 1'b0;
        check_eq("t2_ack_after_pop", CPUReadComplete, 1);
        check_eq("t2_stall_clear", Stalled, 0);
        check_eq("t2_count_after_pop", FifoCount, 4);
        AnalogValReady = 1'b0;
        wait_ack(1'b0, "t2_ack_fall");
        for (int i = 1; i <= 4; i++) pop_one(16'(100 + i), "t2_drain");
        check_eq("t2_count_drained", FifoCount, 0);

        // Acknowledge timeout, clear, and clear colliding with a timeout.
        AnalogReading  = 16'h0bad;
        AnalogValReady = 1'b1;
        wait_ack(1'b1, "t3_ack_rise");
        repeat (ACK_TIMEOUT - 1) tick();
        check_eq("t3_no_tmo_yet", TimeoutErr, 0);
        check_eq("t3_ack_still", CPUReadComplete, 1);
        tick();
        AnalogValReady = 1'b0;
        check_eq("t3_tmo_set", TimeoutErr, 1);
        check_eq("t3_ack_dropped", CPUReadComplete, 0);
        repeat (3) tick();
        check_eq("t3_tmo_sticky", TimeoutErr, 1);
        ClrErr = 1'b1;
        tick();
        ClrErr = 1'b0;
        check_eq("t3_tmo_cleared", TimeoutErr, 0);
        AnalogReading  = 16'h0bee;
        AnalogValReady = 1'b1;
        wait_ack(1'b1, "t3_ack_rise2");
        repeat (ACK_TIMEOUT - 1) tick();
        ClrErr = 1'b1;
        tick();
        ClrErr = 1'b0;
        AnalogValReady = 1'b0;
        check_eq("t3_tmo_wins_clear", TimeoutErr, 1);
        check_eq("t3_ack_dropped2", CPUReadComplete, 0);
        ClrErr = 1'b1;
        tick();
        ClrErr = 1'b0;
        check_eq("t3_count", FifoCount, 2);
        pop_one(16'h0bad, "t3_pop1");
        pop_one(16'h0bee, "t3_pop2");

        // Mode change during ACK.
        AnalogReading  = 16'd500;
        AnalogValReady = 1'b1;
        wait_ack(1'b1, "t4_ack_rise");
        CfgMode = 2'd1;
        tick();
        check_eq("t4_mode_fast", Mode, 1);
        check_eq("t4_ack_held", CPUReadComplete, 1);
        AnalogValReady = 1'b0;
        wait_ack(1'b0, "t4_ack_fall");
        repeat (2) tick();
        check_eq("t4_count", FifoCount, 1);
        pop_one(16'd500, "t4_pop");
        CfgMode = 2'd3;
        repeat (2) tick();
        check_eq("t4_mode_reserved", Mode, 1);

        // Asynchronous reset mid-ACK with two entries.
        send(16'd600, 3'd1);
        AnalogReading  = 16'd601;
        ErrorCode      = 3'd2;
        AnalogValReady = 1'b1;
        wait_ack(1'b1, "t5_ack_rise");
        check_eq("t5_count_pre", FifoCount, 2);
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        CfgEnable = 1'b0;
        tick();
        Rst_n = 1'b1;
        repeat (4) tick();
        check_eq("t5_idle_ack", CPUReadComplete, 0);
        check_eq("t5_idle_count", FifoCount, 0);
        CfgEnable = 1'b1;
        wait_ack(1'b1, "t5_ack_after_enable");
        check_eq("t5_count_post", FifoCount, 1);
        check_eq("t5_popdata", PopData, 601);
        AnalogValReady = 1'b0;
        wait_ack(1'b0, "t5_ack_fall");
        tick();
        pop_one(16'd601, "t5_pop");

        // Pop on empty is ignored; push and pop in the same cycle at count 1.
        PopReq = 1'b1;
        tick();
        PopReq = 1'b0;
        check_eq("t6_empty_pop_count", FifoCount, 0);
        check_eq("t6_empty_pop_data", PopData, last_pop);
        send(16'd700, 3'd5);
        tick();
        AnalogReading  = 16'd701;
        ErrorCode      = 3'd6;
        AnalogValReady = 1'b1;
        check_eq("t6_head_before", PopData, 700);
        PopReq = 1'b1;
        tick();
        PopReq = 1'b0;
        check_eq("t6_ack", CPUReadComplete, 1);
        check_eq("t6_count_same", FifoCount, 1);
        check_eq("t6_head_advanced", PopData, 701);
        check_eq("t6_code_advanced", PopCode, 6);
        AnalogValReady = 1'b0;
        wait_ack(1'b0, "t6_ack_fall");
        tick();
        pop_one(16'd701, "t6_pop");

        // Randomized traffic against the sample-queue model.
        CfgMode = 2'd1;
        tick();
        exp_mode = 2'd1;
        q.delete();
        ph = 0;
        for (int cyc = 0; cyc < 3000; cyc++) step_random(1'b1);
        for (int cyc = 0; cyc < 400 && (ph != 0 || q.size() != 0); cyc++) step_random(1'b0);
        check_eq("rnd_drained", FifoCount, 0);
        check_eq("rnd_progress", n_acc > 100, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
